// File: rtl/led_counter_ctrl.sv
module led_counter_ctrl #(
  parameter int unsigned PRESCALE    = 12_000_000,
  parameter int unsigned DEBOUNCE    = 240_000,
  parameter int unsigned STOP_AT_MAX = 1,
  parameter int unsigned CLR_CYCLES  = 2
) (
  input  logic       clkpulse,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_step,
  input  logic       btn_clr,
  input  logic [3:0] leds,
  output logic       cnt_tick,
  output logic       cnt_clr_n,
  output logic [1:0] mode
);

  localparam int unsigned PW = $clog2(PRESCALE);
  localparam int unsigned DW = $clog2(DEBOUNCE);
  localparam int unsigned CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  localparam logic [PW-1:0] PS_MAX  = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] CLR_MAX = CW'(CLR_CYCLES - 1);

  typedef enum logic [1:0] {
    HOLD  = 2'b00,
    RUN   = 2'b01,
    CLEAR = 2'b10
  } state_t;

  // Bit order for all per-button vectors: [0]=step, [1]=mode, [2]=clr.
  logic [2:0]    btn_raw;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    deb;
  logic [2:0]    deb_d;
  logic [2:0]    evt;
  logic [DW-1:0] dcnt [3];

  logic ev_step;
  logic ev_mode;
  logic ev_clr;

  state_t        state;
  logic [PW-1:0] psc;
  logic [CW-1:0] ccnt;

  assign btn_raw = {btn_clr, btn_mode, btn_step};
  assign ev_step = evt[0];
  assign ev_mode = evt[1];
  assign ev_clr  = evt[2];

  always_ff @(posedge clkpulse or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      evt   <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        dcnt[i] <= '0;
      end
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      deb_d <= deb;
      // Event is taken one cycle after the debounced rise so it comes from a flop.
      evt   <= deb & ~deb_d;
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DB_MAX) begin
          deb[i]  <= sync2[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clkpulse or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HOLD;
      cnt_tick  <= 1'b0;
      cnt_clr_n <= 1'b1;
      psc       <= '0;
      ccnt      <= '0;
    end else begin
      cnt_tick <= 1'b0;
      unique case (state)
        HOLD: begin
          if (ev_clr) begin
            state     <= CLEAR;
            cnt_clr_n <= 1'b0;
            ccnt      <= '0;
          end else if (ev_mode) begin
            state <= RUN;
            psc   <= '0;
          end else if (ev_step) begin
            cnt_tick <= 1'b1;
          end
        end
        RUN: begin
          if (ev_clr) begin
            state     <= CLEAR;
            cnt_clr_n <= 1'b0;
            ccnt      <= '0;
          end else if (ev_mode) begin
            state <= HOLD;
          end else if (psc == PS_MAX) begin
            psc <= '0;
            if ((STOP_AT_MAX != 0) && (leds == 4'hF)) begin
              state <= HOLD;
            end else begin
              cnt_tick <= 1'b1;
            end
          end else begin
            psc <= psc + 1'b1;
          end
        end
        CLEAR: begin
          if (ccnt == CLR_MAX) begin
            cnt_clr_n <= 1'b1;
            state     <= HOLD;
          end else begin
            ccnt <= ccnt + 1'b1;
          end
        end
        default: begin
          state     <= HOLD;
          cnt_clr_n <= 1'b1;
        end
      endcase
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_led_counter_ctrl.sv
module tb_led_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       bm = 1'b0;
  logic       bs = 1'b0;
  logic       bc = 1'b0;

  logic       tick_s, clrn_s, tick_w, clrn_w;
  logic [1:0] mode_s, mode_w;
  logic [3:0] leds_s, leds_w;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  led_counter_ctrl #(
    .PRESCALE(5), .DEBOUNCE(4), .STOP_AT_MAX(1), .CLR_CYCLES(2)
  ) u_stop (
    .clkpulse(clk), .rst_n(rst_n), .btn_mode(bm), .btn_step(bs), .btn_clr(bc),
    .leds(leds_s), .cnt_tick(tick_s), .cnt_clr_n(clrn_s), .mode(mode_s)
  );

  led_counter_ctrl #(
    .PRESCALE(5), .DEBOUNCE(4), .STOP_AT_MAX(0), .CLR_CYCLES(2)
  ) u_wrap (
    .clkpulse(clk), .rst_n(rst_n), .btn_mode(bm), .btn_step(bs), .btn_clr(bc),
    .leds(leds_w), .cnt_tick(tick_w), .cnt_clr_n(clrn_w), .mode(mode_w)
  );

  // Board-level 4-bit counters: clocked by cnt_tick, async cleared by cnt_clr_n.
  always @(posedge tick_s or negedge clrn_s or negedge rst_n)
    if (!rst_n || !clrn_s) leds_s <= 4'h0;
    else                   leds_s <= leds_s + 4'h1;

  always @(posedge tick_w or negedge clrn_w or negedge rst_n)
    if (!rst_n || !clrn_w) leds_w <= 4'h0;
    else                   leds_w <= leds_w + 4'h1;

  typedef struct {
    logic        bm;
    logic        bs;
    logic        bc;
    int unsigned n;
    logic [7:0]  exp_s;
    logic [7:0]  exp_w;
  } vec_t;

  vec_t vq[$];

  function automatic logic [7:0] ex(input logic t, input logic c, input logic [1:0] m,
                                    input logic [3:0] l);
    return {t, c, m, l};
  endfunction

  function automatic logic [15:0] outs();
    return {tick_s, clrn_s, mode_s, leds_s, tick_w, clrn_w, mode_w, leds_w};
  endfunction

  task automatic add(input logic m, input logic s, input logic c, input int unsigned n,
                     input logic [7:0] es, input logic [7:0] ew);
    vec_t v;
    v.bm = m; v.bs = s; v.bc = c; v.n = n; v.exp_s = es; v.exp_w = ew;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got stop/wrap {tick,clr_n,mode,leds}=%b_%b want %b_%b",
               name, got[15:8], got[7:0], exp[15:8], exp[7:0]);
    end
  endtask

  task automatic cyc(input logic m, input logic s, input logic c);
    @(negedge clk);
    bm = m; bs = s; bc = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst_n = 1'b0;
    bm = 1'b0; bs = 1'b0; bc = 1'b0;
    #1;
    chk(name, outs(), {ex(0, 1, 2'b00, 4'h0), ex(0, 1, 2'b00, 4'h0)});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0]  es, ew;
    logic [1:0]  m;
    logic [3:0]  l;
    logic        t;
    logic        c;
    int unsigned nt;

    // Step press in HOLD: one tick 7 edges after first sampled high.
    add(0, 1, 0, 7,  ex(0, 1, 2'b00, 4'h0), ex(0, 1, 2'b00, 4'h0));
    add(0, 1, 0, 1,  ex(1, 1, 2'b00, 4'h1), ex(1, 1, 2'b00, 4'h1));
    add(0, 1, 0, 2,  ex(0, 1, 2'b00, 4'h1), ex(0, 1, 2'b00, 4'h1));
    add(0, 0, 0, 10, ex(0, 1, 2'b00, 4'h1), ex(0, 1, 2'b00, 4'h1));
    // 3-cycle glitch on mode: rejected.
    add(1, 0, 0, 3,  ex(0, 1, 2'b00, 4'h1), ex(0, 1, 2'b00, 4'h1));
    add(0, 0, 0, 10, ex(0, 1, 2'b00, 4'h1), ex(0, 1, 2'b00, 4'h1));
    // Mode press -> RUN at edge 7, ticks at 12,17,...; step held 21..30 is ignored.
    // Stop instance reaches F at edge 77 and drops to HOLD at 82; wrap instance wraps.
    for (int unsigned e = 0; e < 96; e++) begin
      nt = (e >= 7) ? (e - 7) / 5 : 0;
      t  = (e >= 12) && ((e - 7) % 5 == 0);
      m  = (e >= 7) ? 2'b01 : 2'b00;
      ew = ex(t, 1'b1, m, 4'((1 + nt) % 16));
      l  = (1 + nt > 15) ? 4'hF : 4'(1 + nt);
      es = ex(t && (e <= 77), 1'b1, (e >= 82) ? 2'b00 : m, l);
      add(e < 7, (e >= 21) && (e <= 30), 0, 1, es, ew);
    end

    do_reset("reset_initial");
    foreach (vq[i]) begin
      for (int unsigned r = 0; r < vq[i].n; r++) begin
        @(negedge clk);
        bm = vq[i].bm; bs = vq[i].bs; bc = vq[i].bc;
        @(posedge clk);
        #1;
        chk($sformatf("vec%0d.%0d", i, r), outs(), {vq[i].exp_s, vq[i].exp_w});
      end
    end

    // Clear and mode events land together in RUN: clear wins, mode event lost.
    do_reset("reset_before_clr");
    for (int unsigned e = 0; e < 50; e++) begin
      cyc((e < 6) || (e >= 21 && e < 27), 1'b0, (e >= 21 && e < 27));
      t = (e == 12) || (e == 17) || (e == 22) || (e == 27);
      c = !(e == 28 || e == 29);
      if (e < 7)       m = 2'b00;
      else if (e < 28) m = 2'b01;
      else if (e < 30) m = 2'b10;
      else             m = 2'b00;
      if (e < 12)      l = 4'h0;
      else if (e < 17) l = 4'h1;
      else if (e < 22) l = 4'h2;
      else if (e < 27) l = 4'h3;
      else if (e < 28) l = 4'h4;
      else             l = 4'h0;
      chk($sformatf("clr_mode.%0d", e), outs(), {ex(t, c, m, l), ex(t, c, m, l)});
    end

    // Reset asserted one cycle after cnt_clr_n falls, with step held through release.
    for (int unsigned e = 0; e < 9; e++) begin
      cyc(1'b0, 1'b0, e < 6);
      m = (e >= 7) ? 2'b10 : 2'b00;
      c = (e < 7);
      chk($sformatf("clr_entry.%0d", e), outs(), {ex(0, c, m, 4'h0), ex(0, c, m, 4'h0)});
    end
    #2;
    rst_n = 1'b0;
    bs = 1'b1;
    #1;
    chk("async_reset", outs(), {ex(0, 1, 2'b00, 4'h0), ex(0, 1, 2'b00, 4'h0)});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int unsigned e = 0; e < 30; e++) begin
      @(posedge clk);
      #1;
      t = (e == 7);
      l = (e >= 7) ? 4'h1 : 4'h0;
      chk($sformatf("held_step.%0d", e), outs(), {ex(t, 1, 2'b00, l), ex(t, 1, 2'b00, l)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
